// File: rtl/pcie_fc_pkg.sv
// Shared widths and FSM state encoding for the PCIe flow-control credit block.
package pcie_fc_pkg;

  localparam int HDR_W  = 8;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    FC_IDLE   = 2'd0,
    FC_INIT   = 2'd1,
    FC_ACTIVE = 2'd2
  } fc_state_t;

endpackage

// File: rtl/pcie_fc_credit_cnt.sv
// Per-VC credit bookkeeping: credit limit, credits consumed, infinite flags
// and the "head TLP fits" comparison.
module pcie_fc_credit_cnt #(
  parameter int HDR_W  = pcie_fc_pkg::HDR_W,
  parameter int DATA_W = pcie_fc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              active,
  input  logic              init_load,
  input  logic [HDR_W-1:0]  init_hdr,
  input  logic [DATA_W-1:0] init_data,
  input  logic              upd_load,
  input  logic [HDR_W-1:0]  upd_hdr,
  input  logic [DATA_W-1:0] upd_data,
  input  logic              consume,
  input  logic [DATA_W-1:0] need,
  output logic              init_done,
  output logic              fc_ok
);

  localparam logic [HDR_W-1:0]  HDR_ONE   = {{(HDR_W-1){1'b0}}, 1'b1};
  localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};

  logic [HDR_W-1:0]  cl_hdr;
  logic [HDR_W-1:0]  cc_hdr;
  logic [DATA_W-1:0] cl_data;
  logic [DATA_W-1:0] cc_data;
  logic              hdr_inf;
  logic              data_inf;
  logic [HDR_W-1:0]  hdr_room;
  logic [DATA_W-1:0] data_room;
  logic              hdr_ok;
  logic              data_ok;

  // Credit registers: InitFC loads, UpdateFC replaces the limit, consume advances the counters.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cl_hdr    <= '0;
      cc_hdr    <= '0;
      cl_data   <= '0;
      cc_data   <= '0;
      hdr_inf   <= 1'b0;
      data_inf  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      if (init_load) begin
        cl_hdr    <= init_hdr;
        cl_data   <= init_data;
        hdr_inf   <= (init_hdr == '0);
        data_inf  <= (init_data == '0);
        cc_hdr    <= '0;
        cc_data   <= '0;
        init_done <= 1'b1;
      end
      if (upd_load) begin
        cl_hdr  <= upd_hdr;
        cl_data <= upd_data;
      end
      if (consume) begin
        cc_hdr  <= cc_hdr + HDR_ONE;
        cc_data <= cc_data + need;
      end
    end
  end

  // Modular "limit minus what would be consumed" must land in the lower half of the ring.
  always_comb begin
    hdr_room  = cl_hdr - cc_hdr - HDR_ONE;
    data_room = cl_data - cc_data - need;
    hdr_ok    = hdr_inf || (hdr_room <= HDR_HALF);
    data_ok   = data_inf || (data_room <= DATA_HALF);
    fc_ok     = active && hdr_ok && data_ok;
  end

endmodule

// File: rtl/pcie_fc_credit_ctrl.sv
// Transmit-side flow-control credit controller: link FSM plus one credit
// counter per virtual channel, feeding the TLP arbiter's fc inputs.
module pcie_fc_credit_ctrl #(
  parameter int NUM_VC = 2,
  parameter int HDR_W  = pcie_fc_pkg::HDR_W,
  parameter int DATA_W = pcie_fc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              link_up_i,
  input  logic              initfc_valid_i,
  input  logic              initfc_vc_i,
  input  logic [HDR_W-1:0]  initfc_hdr_i,
  input  logic [DATA_W-1:0] initfc_data_i,
  input  logic              updfc_valid_i,
  input  logic              updfc_vc_i,
  input  logic [HDR_W-1:0]  updfc_hdr_i,
  input  logic [DATA_W-1:0] updfc_data_i,
  input  logic [DATA_W-1:0] vc0_need_i,
  input  logic [DATA_W-1:0] vc1_need_i,
  input  logic              consume_valid_i,
  input  logic              consume_vc_i,
  output logic              vc0_fc_ok_o,
  output logic              vc1_fc_ok_o,
  output logic              fc_valid_o,
  output logic [1:0]        fc_state_o,
  output logic              fc_err_o
);

  import pcie_fc_pkg::*;

  fc_state_t         state_q;
  fc_state_t         state_d;
  logic              active;
  logic              link_clear;
  logic              consume_err;
  logic [NUM_VC-1:0] vc_ok;
  logic [NUM_VC-1:0] vc_init_done;
  logic [NUM_VC-1:0] vc_init_cap;

  assign active     = (state_q == FC_ACTIVE);
  assign link_clear = !link_up_i;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    localparam logic VC_ID = 1'(g);
    logic [DATA_W-1:0] need;
    logic              upd_load;
    logic              consume;

    assign need           = (g == 0) ? vc0_need_i : vc1_need_i;
    assign vc_init_cap[g] = (state_q == FC_INIT) && initfc_valid_i &&
                            (initfc_vc_i == VC_ID) && !vc_init_done[g];
    assign upd_load       = active && updfc_valid_i && (updfc_vc_i == VC_ID);
    assign consume        = active && consume_valid_i && (consume_vc_i == VC_ID);

    pcie_fc_credit_cnt #(
      .HDR_W (HDR_W),
      .DATA_W(DATA_W)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (link_clear),
      .active   (active),
      .init_load(vc_init_cap[g]),
      .init_hdr (initfc_hdr_i),
      .init_data(initfc_data_i),
      .upd_load (upd_load),
      .upd_hdr  (updfc_hdr_i),
      .upd_data (updfc_data_i),
      .consume  (consume),
      .need     (need),
      .init_done(vc_init_done[g]),
      .fc_ok    (vc_ok[g])
    );
  end

  // Link FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: ACTIVE as soon as the edge that captures the last InitFC has passed; link loss wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FC_IDLE:   if (link_up_i) state_d = FC_INIT;
      FC_INIT:   if (&(vc_init_done | vc_init_cap)) state_d = FC_ACTIVE;
      FC_ACTIVE: state_d = FC_ACTIVE;
      default:   state_d = FC_IDLE;
    endcase
    if (!link_up_i) state_d = FC_IDLE;
  end

  assign consume_err = active && consume_valid_i && !vc_ok[consume_vc_i];

  // Sticky overrun flag: a dispatch was made against a VC whose head TLP did not fit.
  always_ff @(posedge clk) begin
    if (!rst_n || link_clear) begin
      fc_err_o <= 1'b0;
    end else if (consume_err) begin
      fc_err_o <= 1'b1;
    end
  end

  assign vc0_fc_ok_o = vc_ok[0];
  assign vc1_fc_ok_o = vc_ok[1];
  assign fc_valid_o  = active && (|vc_ok);
  assign fc_state_o  = state_q;

endmodule

// File: tb/tb_pcie_fc_credit_ctrl.sv
// Directed bench for the flow-control credit controller with hand-computed expectations.
module tb_pcie_fc_credit_ctrl;

  localparam int HDR_W  = 8;
  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              link_up;
  logic              initfc_valid;
  logic              initfc_vc;
  logic [HDR_W-1:0]  initfc_hdr;
  logic [DATA_W-1:0] initfc_data;
  logic              updfc_valid;
  logic              updfc_vc;
  logic [HDR_W-1:0]  updfc_hdr;
  logic [DATA_W-1:0] updfc_data;
  logic [DATA_W-1:0] vc0_need;
  logic [DATA_W-1:0] vc1_need;
  logic              consume_valid;
  logic              consume_vc;
  logic              vc0_fc_ok;
  logic              vc1_fc_ok;
  logic              fc_valid;
  logic [1:0]        fc_state;
  logic              fc_err;

  int check_count = 0;
  int fail_count  = 0;

  pcie_fc_credit_ctrl #(
    .NUM_VC(2),
    .HDR_W (HDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .link_up_i      (link_up),
    .initfc_valid_i (initfc_valid),
    .initfc_vc_i    (initfc_vc),
    .initfc_hdr_i   (initfc_hdr),
    .initfc_data_i  (initfc_data),
    .updfc_valid_i  (updfc_valid),
    .updfc_vc_i     (updfc_vc),
    .updfc_hdr_i    (updfc_hdr),
    .updfc_data_i   (updfc_data),
    .vc0_need_i     (vc0_need),
    .vc1_need_i     (vc1_need),
    .consume_valid_i(consume_valid),
    .consume_vc_i   (consume_vc),
    .vc0_fc_ok_o    (vc0_fc_ok),
    .vc1_fc_ok_o    (vc1_fc_ok),
    .fc_valid_o     (fc_valid),
    .fc_state_o     (fc_state),
    .fc_err_o       (fc_err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One clock edge, sample point 1 unit later, then drop the single-cycle pulses.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    initfc_valid  = 1'b0;
    updfc_valid   = 1'b0;
    consume_valid = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_state"}, 32'(fc_state), 0);
    checkOutput({tag, "_fc_valid"}, 32'(fc_valid), 0);
    checkOutput({tag, "_vc0_ok"}, 32'(vc0_fc_ok), 0);
    checkOutput({tag, "_vc1_ok"}, 32'(vc1_fc_ok), 0);
    checkOutput({tag, "_err"}, 32'(fc_err), 0);
  endtask

  // Main directed sequence.
  initial begin
    rst_n = 1'b0; link_up = 1'b0;
    initfc_valid = 1'b0; initfc_vc = 1'b0; initfc_hdr = '0; initfc_data = '0;
    updfc_valid = 1'b0; updfc_vc = 1'b0; updfc_hdr = '0; updfc_data = '0;
    vc0_need = '0; vc1_need = '0; consume_valid = 1'b0; consume_vc = 1'b0;

    repeat (2) applyStimulus();
    checkIdleOutputs("reset");

    // Bring-up: InitFC VC0 hdr=4 data=16, VC1 hdr=2 data=8.
    rst_n = 1'b1; link_up = 1'b1;
    applyStimulus();
    checkOutput("idle_to_init", 32'(fc_state), 1);
    vc0_need = 12'd16; vc1_need = 12'd8;
    initfc_valid = 1'b1; initfc_vc = 1'b0; initfc_hdr = 8'd4; initfc_data = 12'd16;
    applyStimulus();
    checkOutput("init_wait_vc1", 32'(fc_state), 1);
    checkOutput("init_vc0_ok_gated", 32'(vc0_fc_ok), 0);
    initfc_valid = 1'b1; initfc_vc = 1'b1; initfc_hdr = 8'd2; initfc_data = 12'd8;
    applyStimulus();
    checkOutput("active_after_init", 32'(fc_state), 2);
    checkOutput("active_fc_valid", 32'(fc_valid), 1);
    checkOutput("vc0_ok_exact16", 32'(vc0_fc_ok), 1);
    checkOutput("vc1_ok_exact8", 32'(vc1_fc_ok), 1);

    // Two VC1 consumes of 4 data credits exhaust VC1.
    vc1_need = 12'd4;
    repeat (2) begin
      consume_valid = 1'b1; consume_vc = 1'b1;
      applyStimulus();
    end
    vc1_need = 12'd1; #1;
    checkOutput("vc1_full_need1", 32'(vc1_fc_ok), 0);
    vc1_need = 12'd4; #1;
    checkOutput("vc1_full_need4", 32'(vc1_fc_ok), 0);
    checkOutput("vc0_untouched16", 32'(vc0_fc_ok), 1);
    vc0_need = 12'd17; #1;
    checkOutput("vc0_untouched17", 32'(vc0_fc_ok), 0);
    checkOutput("fc_valid_none_ok", 32'(fc_valid), 0);
    checkOutput("no_err_yet", 32'(fc_err), 0);
    vc0_need = 12'd16;

    // UpdateFC and consume on VC1 in one cycle: CL_data=16, CC_data=12, CL_hdr=8, CC_hdr=3.
    updfc_valid = 1'b1; updfc_vc = 1'b1; updfc_hdr = 8'd8; updfc_data = 12'd16;
    consume_valid = 1'b1; consume_vc = 1'b1;
    applyStimulus();
    checkOutput("upd_consume_need4", 32'(vc1_fc_ok), 1);
    vc1_need = 12'd5; #1;
    checkOutput("upd_consume_need5", 32'(vc1_fc_ok), 0);
    checkOutput("err_consume_not_ok", 32'(fc_err), 1);

    // Link drop in the middle of traffic.
    consume_valid = 1'b1; consume_vc = 1'b0;
    link_up = 1'b0;
    applyStimulus();
    checkIdleOutputs("link_down");

    // Re-train: VC0 infinite credits, VC1 data=4090 with infinite headers.
    link_up = 1'b1;
    applyStimulus();
    checkOutput("retrain_init", 32'(fc_state), 1);
    initfc_valid = 1'b1; initfc_vc = 1'b0; initfc_hdr = 8'd0; initfc_data = 12'd0;
    applyStimulus();
    vc0_need = 12'd0; #1;
    checkOutput("init_vc0_inf_gated", 32'(vc0_fc_ok), 0);
    initfc_valid = 1'b1; initfc_vc = 1'b0; initfc_hdr = 8'd1; initfc_data = 12'd1;
    consume_valid = 1'b1; consume_vc = 1'b1; vc1_need = 12'd100;
    applyStimulus();
    checkOutput("repeat_initfc_wait", 32'(fc_state), 1);
    initfc_valid = 1'b1; initfc_vc = 1'b1; initfc_hdr = 8'd0; initfc_data = 12'd4090;
    applyStimulus();
    checkOutput("retrain_active", 32'(fc_state), 2);
    vc1_need = 12'd4090; #1;
    checkOutput("cc_cleared_need4090", 32'(vc1_fc_ok), 1);
    vc1_need = 12'd4091; #1;
    checkOutput("cc_cleared_need4091", 32'(vc1_fc_ok), 0);
    vc0_need = 12'd4095; #1;
    checkOutput("vc0_inf_repeat_ignored", 32'(vc0_fc_ok), 1);

    // Wrap: CC_data=4088 against CL_data=4090, then UpdateFC 6 (4102 mod 4096).
    vc1_need = 12'd4088;
    consume_valid = 1'b1; consume_vc = 1'b1;
    applyStimulus();
    vc1_need = 12'd2; #1;
    checkOutput("near_wrap_need2", 32'(vc1_fc_ok), 1);
    vc1_need = 12'd3; #1;
    checkOutput("near_wrap_need3", 32'(vc1_fc_ok), 0);
    updfc_valid = 1'b1; updfc_vc = 1'b1; updfc_hdr = 8'd0; updfc_data = 12'd6;
    applyStimulus();
    vc1_need = 12'd8; #1;
    checkOutput("wrapped_limit_need8", 32'(vc1_fc_ok), 1);
    vc1_need = 12'd15; #1;
    checkOutput("wrapped_limit_need15", 32'(vc1_fc_ok), 0);
    vc1_need = 12'd8;
    consume_valid = 1'b1; consume_vc = 1'b1;
    applyStimulus();
    vc1_need = 12'd6; #1;
    checkOutput("cc_wrapped_need6", 32'(vc1_fc_ok), 1);
    vc1_need = 12'd7; #1;
    checkOutput("cc_wrapped_need7", 32'(vc1_fc_ok), 0);
    checkOutput("wrap_no_err", 32'(fc_err), 0);

    // 300 consumes on the infinite-credit VC never run it dry.
    vc0_need = 12'd100;
    for (int i = 0; i < 300; i++) begin
      consume_valid = 1'b1; consume_vc = 1'b0;
      applyStimulus();
    end
    vc0_need = 12'd4095; #1;
    checkOutput("vc0_inf_after_300", 32'(vc0_fc_ok), 1);
    checkOutput("inf_no_err", 32'(fc_err), 0);

    // Overrun on VC1 (need 7 against 6 remaining) sets a sticky error.
    vc1_need = 12'd7;
    consume_valid = 1'b1; consume_vc = 1'b1;
    applyStimulus();
    checkOutput("overrun_err", 32'(fc_err), 1);
    repeat (3) applyStimulus();
    checkOutput("overrun_err_sticky", 32'(fc_err), 1);

    // Synchronous reset while ACTIVE.
    rst_n = 1'b0;
    applyStimulus();
    checkIdleOutputs("mid_reset");
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("post_reset_init", 32'(fc_state), 1);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/pcie_fc_credit_ctrl.md
PCIE_FC_CREDIT_CTRL -- requirements
Module: pcie_fc_credit_ctrl

Interface
REQ-001 SHALL have parameter NUM_VC, default 2, meaning number of virtual channels; only 2 is supported.
REQ-002 SHALL have parameter HDR_W, default 8, meaning header-credit counter width.
REQ-003 SHALL have parameter DATA_W, default 12, meaning data-credit counter width.
REQ-004 SHALL have port clk  input  1  meaning single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning reset, synchronous, active-low.
REQ-006 SHALL have port link_up_i  input  1  meaning link up; its deassertion forces IDLE.
REQ-007 SHALL have port initfc_valid_i  input  1  meaning InitFC DLLP received.
REQ-008 SHALL have port initfc_vc_i  input  1  meaning InitFC target VC.
REQ-009 SHALL have port initfc_hdr_i  input  HDR_W  meaning advertised header credits.
REQ-010 SHALL have port initfc_data_i  input  DATA_W  meaning advertised data credits.
REQ-011 SHALL have port updfc_valid_i  input  1  meaning UpdateFC DLLP received.
REQ-012 SHALL have port updfc_vc_i  input  1  meaning UpdateFC target VC.
REQ-013 SHALL have port updfc_hdr_i  input  HDR_W  meaning new cumulative header credit limit.
REQ-014 SHALL have port updfc_data_i  input  DATA_W  meaning new cumulative data credit limit.
REQ-015 SHALL have ports vc0_need_i and vc1_need_i  input  DATA_W  meaning data credits needed by each VC head TLP.
REQ-016 SHALL have ports consume_valid_i, consume_vc_i  input  1 each  meaning TLP dispatched from that VC (arbiter read-enable).
REQ-017 SHALL have ports vc0_fc_ok_o and vc1_fc_ok_o  output  1  meaning head TLP of that VC fits the credit limit.
REQ-018 SHALL have port fc_valid_o  output  1  meaning ACTIVE and at least one VC fc_ok; drives the arbiter flow-control input.
REQ-019 SHALL have port fc_state_o  output  2  meaning current FSM state.
REQ-020 SHALL have port fc_err_o  output  1  meaning sticky credit-overrun error.

Function
REQ-021 SHALL implement FSM states IDLE(0), INIT(1), ACTIVE(2).
REQ-022 SHALL transition IDLE->INIT when link_up_i=1.
REQ-023 SHALL transition INIT->ACTIVE in the cycle after InitFC has been captured for both VC0 and VC1.
REQ-024 SHALL transition from any state to IDLE when link_up_i=0, clearing all limits, consumed counters and InitFC flags.
REQ-025 SHALL in INIT load per-VC credit limit CL from initfc_hdr_i/initfc_data_i, and set the consumed counter CC to 0.
REQ-026 SHALL treat an InitFC value of 0 as infinite credit; the infinite flag is kept per VC per type, and the check always passes for that type.
REQ-027 SHALL use only the first InitFC received per VC; repeats are ignored, as is InitFC received in ACTIVE.
REQ-028 SHALL in ACTIVE replace CL with the updfc values on updfc_valid_i; UpdateFC received outside ACTIVE is ignored.
REQ-029 SHALL on consume_valid_i in ACTIVE add 1 to the header CC and add the need of the selected VC to the data CC.
REQ-030 SHALL perform all counter arithmetic modulo 2^HDR_W and 2^DATA_W, respectively.
REQ-031 SHALL assert vcN_fc_ok_o only when ALL of the following hold: state is ACTIVE; (CL_hdr-(CC_hdr+1)) mod 2^HDR_W <= 2^(HDR_W-1); and (CL_data-(CC_data+need)) mod 2^DATA_W <= 2^(DATA_W-1).
REQ-032 SHALL compute fc_ok combinationally from registered CL/CC and the need inputs; a consume at cycle N is reflected in cycle N+1.
REQ-033 SHALL, when consume and UpdateFC target the same VC in the same cycle, apply both: the new CL and the incremented CC.
REQ-034 SHALL, on consume while the target vcN_fc_ok_o=0, still apply the consume and set fc_err_o until reset or IDLE.
REQ-035 SHALL ignore consume_valid_i outside ACTIVE.

Reset
REQ-036 SHALL on rst_n=0 at a clock edge set state to IDLE, CL/CC/flags to 0, and every output to 0; this applies equally mid-operation.

Structure
REQ-037 SHALL place HDR_W, DATA_W and the fc_state_t enum in shared package pcie_fc_pkg.
REQ-038 SHALL instantiate one sub-module pcie_fc_credit_cnt per VC, holding CL, CC, the infinite flags and the fc_ok compare.

Verification
REQ-039 SHALL test: reset, link_up=1, InitFC VC0 hdr=4 data=16, VC1 hdr=2 data=8 -> state ACTIVE 1 cycle after the second InitFC; fc_valid_o=1.
REQ-040 SHALL test: VC1 need=4, two consumes -> VC1 CC_data=8, vc1_fc_ok_o=0 for need>=1; VC0 unaffected.
REQ-041 SHALL test: VC1 UpdateFC data=16 in the same cycle as a consume with need=4 -> CL=16, CC=12, vc1_fc_ok_o=1 for need=4.
REQ-042 SHALL test: CL_data=4090 and CC_data=4088, then UpdateFC 6 (wrapped) and need=8 -> fc_ok=1; CC wraps to 0.
REQ-043 SHALL test: InitFC VC0 hdr=0 data=0 -> vc0_fc_ok_o=1 after 300 consumes; consume when ok=0 -> fc_err_o=1 sticky.
REQ-044 SHALL test: link_up_i=0 mid-traffic -> state IDLE next cycle; fc_valid_o=0 and counters 0; rst_n=0 mid-ACTIVE gives the same result.
